// File: rtl/data_pack.sv
// Packs LSB-aligned 7-bit values into 32-bit words, LSB-first, carrying sop/eop framing.
// Valid/ready on both sides; a single output holding register drives data_out.
module data_pack (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ready_out,
  input  logic        valid_in,
  input  logic [6:0]  data_in,
  input  logic        sop_in,
  input  logic        eop_in,
  input  logic        ready_in,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic        sop_out,
  output logic        eop_out,
  output logic        err_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PACK  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [30:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic        vld_q, vld_d;
  logic [31:0] data_q, data_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        err_q, err_d;

  logic        slot_free, accept, start, base_first;
  logic [30:0] base_acc;
  logic [4:0]  base_cnt;
  logic [5:0]  total;
  logic [37:0] wide;

  assign slot_free = !vld_q || ready_in;
  assign ready_out = rst_n && (state_q != S_FLUSH) && slot_free;
  assign accept    = valid_in && ready_out;
  assign start     = accept && sop_in;

  // A sop restarts from an empty accumulator whatever was pending.
  assign base_acc   = start ? 31'd0 : acc_q;
  assign base_cnt   = start ? 5'd0  : cnt_q;
  assign base_first = start ? 1'b1  : first_q;
  assign total      = {1'b0, base_cnt} + 6'd7;
  assign wide       = {7'd0, base_acc} | ({31'd0, data_in} << base_cnt);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    vld_d   = vld_q && !ready_in;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    err_d   = 1'b0;

    if (state_q == S_FLUSH) begin
      if (slot_free) begin
        vld_d   = 1'b1;
        data_d  = {1'b0, acc_q};
        sop_d   = first_q;
        eop_d   = 1'b1;
        acc_d   = 31'd0;
        cnt_d   = 5'd0;
        first_d = 1'b0;
        state_d = S_IDLE;
      end
    end else if (accept && (state_q == S_PACK || sop_in)) begin
      err_d   = sop_in && (state_q == S_PACK);
      first_d = base_first;
      state_d = S_PACK;
      if (total >= 6'd32) begin
        vld_d   = 1'b1;
        data_d  = wide[31:0];
        sop_d   = base_first;
        eop_d   = eop_in && (total == 6'd32);
        first_d = 1'b0;
        acc_d   = {25'd0, wide[37:32]};
        cnt_d   = total[4:0];
        if (eop_in) begin
          if (total == 6'd32) begin
            state_d = S_IDLE;
            acc_d   = 31'd0;
            cnt_d   = 5'd0;
          end else begin
            state_d = S_FLUSH;
          end
        end
      end else if (eop_in) begin
        vld_d   = 1'b1;
        data_d  = wide[31:0];
        sop_d   = base_first;
        eop_d   = 1'b1;
        first_d = 1'b0;
        acc_d   = 31'd0;
        cnt_d   = 5'd0;
        state_d = S_IDLE;
      end else begin
        acc_d = wide[30:0];
        cnt_d = total[4:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 31'd0;
      cnt_q   <= 5'd0;
      first_q <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= 32'd0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

  assign valid_out = vld_q;
  assign data_out  = data_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_data_pack.sv
// Bench for data_pack: directed scenarios plus randomized packets checked against a
// bit-stream reference model (concatenate 7-bit values, slice into 32-bit words).
module tb_data_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready_out, valid_in, sop_in, eop_in, ready_in;
  logic [6:0]  data_in;
  logic        valid_out, sop_out, eop_out, err_out;
  logic [31:0] data_out;

  data_pack dut (
    .clk(clk), .rst_n(rst_n), .ready_out(ready_out), .valid_in(valid_in),
    .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .sop_out(sop_out),
    .eop_out(eop_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int err_cnt = 0, hold_err = 0, timeouts = 0, in_stalls = 0;
  bit bp_en = 1'b0;
  logic ro_s;
  logic stall_prev = 1'b0;
  logic [34:0] stall_word;
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  logic [6:0]  pkt_q[$];

  // Advance one cycle: observe outputs at the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    ro_s = ready_out;
    if (err_out) err_cnt++;
    if (valid_out && ready_in) got_q.push_back({sop_out, eop_out, data_out});
    if (stall_prev && ({valid_out, sop_out, eop_out, data_out} !== stall_word)) hold_err++;
    stall_prev = valid_out && !ready_in;
    stall_word = {valid_out, sop_out, eop_out, data_out};
    @(posedge clk);
    #1;
    if (bp_en) ready_in = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [6:0] d, input logic s, input logic e);
    int n = 0;
    valid_in = 1'b1; data_in = d; sop_in = s; eop_in = e;
    do begin
      step();
      n++;
      if (!ro_s) in_stalls++;
    end while (!ro_s && n < 200);
    if (!ro_s) timeouts++;
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
  endtask

  // Reference: stream bit b is bit (b%7) of value b/7; word w covers stream bits [32w+31:32w].
  function automatic void model_pkt();
    int nbits = 7 * pkt_q.size();
    int nw = (nbits + 31) / 32;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word = '0;
      for (int b = 0; b < 32; b++) begin
        int idx = 32 * w + b;
        if (idx < nbits) begin
          logic [6:0] v = pkt_q[idx / 7];
          word[b] = v[idx % 7];
        end
      end
      exp_q.push_back({(w == 0), (w == nw - 1), word});
    end
  endfunction

  task automatic send_pkt();
    model_pkt();
    for (int i = 0; i < pkt_q.size(); i++)
      send(pkt_q[i], (i == 0), (i == pkt_q.size() - 1));
  endtask

  task automatic rand_pkt(input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(7'($urandom));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear();
    got_q.delete(); exp_q.delete(); pkt_q.delete();
    err_cnt = 0; in_stalls = 0; hold_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready_in = 1'b1; valid_in = 1'b1; sop_in = 1'b1; eop_in = 1'b0; data_in = 7'h3;
    drain(3);
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (data_out !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_out); end
    checks++; if (sop_out !== 1'b0) begin failures++; $display("FAIL reset_sop got=%b exp=0", sop_out); end
    checks++; if (eop_out !== 1'b0) begin failures++; $display("FAIL reset_eop got=%b exp=0", eop_out); end
    checks++; if (err_out !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_out); end
    checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_out); end
    valid_in = 1'b0; sop_in = 1'b0; rst_n = 1'b1;
    drain(2);
    clear();
  endtask

  task automatic test_full_pkt_back_to_back();
    logic [6:0] head [5] = '{7'h5A, 7'h00, 7'h33, 7'h00, 7'h7F};
    clear();
    for (int p = 0; p < 2; p++) begin
      rand_pkt(32);
      if (p == 0) for (int i = 0; i < 5; i++) pkt_q[i] = head[i];
      send_pkt();
    end
    drain(3);
    checks++; if (got_q.size() !== 14) begin failures++; $display("FAIL full_count got=%0d exp=14", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== {2'b10, 32'hF00CC05A}) begin failures++; $display("FAIL full_word0 got=%h exp=%h", got_q[0], {2'b10, 32'hF00CC05A}); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (in_stalls !== 0) begin failures++; $display("FAIL full_stalls got=%0d exp=0", in_stalls); end
  endtask

  task automatic test_single();
    clear();
    send(7'h55, 1'b1, 1'b1);
    checks++; if ({valid_out, sop_out, eop_out, data_out} !== {3'b111, 32'h55}) begin failures++; $display("FAIL single_latency got=%b%b%b %h exp=111 00000055", valid_out, sop_out, eop_out, data_out); end
    drain(2);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_flush();
    clear();
    for (int i = 0; i < 5; i++) pkt_q.push_back(7'h7F);
    send_pkt();
    in_stalls = 0;
    pkt_q.delete(); pkt_q.push_back(7'h0C);
    send_pkt();
    checks++; if (in_stalls !== 1) begin failures++; $display("FAIL flush_stall got=%0d exp=1", in_stalls); end
    drain(3);
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL flush_count got=%0d exp=3", got_q.size()); end
    checks++; if (got_q.size() > 1 && (got_q[0] !== {2'b10, 32'hFFFFFFFF} || got_q[1] !== {2'b01, 32'h7})) begin failures++; $display("FAIL flush_words got=%h,%h exp=2ffffffff,100000007", got_q[0], got_q[1]); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL flush_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_no_sop();
    clear();
    send(7'h11, 1'b0, 1'b0);
    send(7'h22, 1'b0, 1'b0);
    drain(3);
    checks++; if (got_q.size() !== 0 || valid_out !== 1'b0) begin failures++; $display("FAIL nosop_out got=%0d words valid=%b exp=0 words valid=0", got_q.size(), valid_out); end
    rand_pkt(9);
    send_pkt();
    drain(3);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL nosop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL nosop_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear();
    ready_in = 1'b0;
    pkt_q.push_back(7'h2A);
    send_pkt();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if ({ro_s, valid_out, data_out} !== {2'b01, 32'h2A}) begin failures++; $display("FAIL bp_hold%0d got=ready%b valid%b %h exp=ready0 valid1 0000002a", c, ro_s, valid_out, data_out); end
    end
    ready_in = 1'b1;
    rand_pkt(6);
    send_pkt();
    drain(3);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", hold_err); end
  endtask

  task automatic test_sop_restart();
    clear();
    send(7'h01, 1'b1, 1'b0);
    send(7'h02, 1'b0, 1'b0);
    send(7'h03, 1'b0, 1'b0);
    rand_pkt(6);
    send_pkt();
    drain(3);
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL restart_err got=%0d exp=1", err_cnt); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL restart_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL restart_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    clear();
    ready_in = 1'b0;
    send(7'h7F, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(7'h7F, 1'b0, 1'b0);
    rst_n = 1'b0;
    drain(2);
    rst_n = 1'b1; ready_in = 1'b1; stall_prev = 1'b0;
    drain(3);
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rstmid_dropped got=%0d exp=0", got_q.size()); end
    rand_pkt(4);
    send_pkt();
    drain(3);
    checks++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin failures++; $display("FAIL rstmid_next got=%0d words first=%h exp=1 words first=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 34'h0, exp_q[0]); end
  endtask

  task automatic test_random();
    int exp_err = 0;
    clear();
    bp_en = 1'b1;
    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 3) == 0) send(7'($urandom), 1'b0, 1'b0);
      if ($urandom_range(0, 5) == 0) begin
        int k = $urandom_range(1, 4);
        send(7'($urandom), 1'b1, 1'b0);
        for (int i = 1; i < k; i++) send(7'($urandom), 1'b0, 1'b0);
        exp_err++;
      end
      rand_pkt($urandom_range(1, 40));
      send_pkt();
    end
    bp_en = 1'b0; ready_in = 1'b1;
    drain(5);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt !== exp_err) begin failures++; $display("FAIL rand_err got=%0d exp=%0d", err_cnt, exp_err); end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL rand_stable got=%0d exp=0", hold_err); end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL handshake_timeout got=%0d exp=0", timeouts); end
  endtask

  initial begin
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0; data_in = '0; ready_in = 1'b1; rst_n = 1'b0;
    test_reset();
    test_full_pkt_back_to_back();
    test_single();
    test_flush();
    test_no_sop();
    test_backpressure();
    test_sop_restart();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
